// File: rtl/if_id_stage.sv
// IF/ID pipeline register: latches fetch output, splits RV32I fields, detects
// load-use hazards, squashes wrong-path slots after a redirect and holds on ecall.
module if_id_stage #(
    parameter int          FLUSH_SLOTS = 1,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        redirect,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ecall_done,
    output logic        stall,
    output logic        ecall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [6:0]  id_opcode,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_funct3,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [6:0]  id_funct7,
    output logic        bubble
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [1:0]  FLUSH_INIT = 2'(FLUSH_SLOTS - 1);
    localparam logic [31:0] ECALL_INST = 32'h0000_0073;

    state_t      state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        hazard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            flush_cnt_q <= 2'd0;
            valid_q     <= 1'b0;
            pc_q        <= 32'd0;
            inst_q      <= NOP_INST;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
        end
    end

    // Invalid slots always present a canonical nop so downstream decode is benign.
    assign id_valid  = valid_q;
    assign id_pc     = pc_q;
    assign id_inst   = valid_q ? inst_q : NOP_INST;
    assign id_opcode = id_inst[6:0];
    assign id_rd     = id_inst[11:7];
    assign id_funct3 = id_inst[14:12];
    assign id_rs1    = id_inst[19:15];
    assign id_rs2    = id_inst[24:20];
    assign id_funct7 = id_inst[31:25];

    // rs2 is compared regardless of format; a spurious stall is harmless.
    assign hazard = valid_q && ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign bubble = (state_q == S_RUN) && !redirect && hazard;
    assign stall  = bubble || (state_q == S_HALT);
    assign ecall  = (state_q == S_HALT);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        valid_d     = valid_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        unique case (state_q)
            S_RUN, S_STALL: begin
                if (redirect) begin
                    valid_d     = 1'b0;
                    flush_cnt_d = FLUSH_INIT;
                    state_d     = (FLUSH_SLOTS > 1) ? S_FLUSH : S_RUN;
                end else if ((state_q == S_RUN) && hazard) begin
                    state_d = S_STALL;
                end else begin
                    pc_d    = if_pc;
                    inst_d  = if_inst;
                    valid_d = (if_inst != 32'd0);
                    state_d = (if_inst == ECALL_INST) ? S_HALT : S_RUN;
                end
            end
            S_FLUSH: begin
                valid_d = 1'b0;
                if (redirect) begin
                    flush_cnt_d = FLUSH_INIT;
                end else begin
                    flush_cnt_d = (flush_cnt_q == 2'd0) ? 2'd0 : flush_cnt_q - 2'd1;
                    if (flush_cnt_q <= 2'd1) state_d = S_RUN;
                end
            end
            S_HALT: begin
                // The ecall slot issues once; afterwards the pipe stays drained.
                valid_d = 1'b0;
                if (ecall_done) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic [31:0] if_inst = 32'd0;
    logic        redirect = 1'b0;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ecall_done = 1'b0;
    logic        stall, ecall, id_valid, bubble;
    logic [31:0] id_pc, id_inst;
    logic [6:0]  id_opcode, id_funct7;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic [2:0]  id_funct3;

    if_id_stage #(.FLUSH_SLOTS(2), .NOP_INST(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst),
        .redirect(redirect), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ecall_done(ecall_done), .stall(stall), .ecall(ecall),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .id_opcode(id_opcode), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct7(id_funct7),
        .bubble(bubble)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] pc;
        logic        chk_pc;
        logic [31:0] inst;
        logic        stall;
        logic        bubble;
        logic        ecall;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Drive one cycle of inputs just after the edge and queue what the outputs
    // must read before the next edge.
    task automatic cyc(input string name, input logic r, input logic [31:0] pc,
                       input logic [31:0] inst, input logic rd_i, input logic mr,
                       input logic [4:0] xr, input logic done,
                       input logic e_v, input logic [31:0] e_pc, input logic e_cpc,
                       input logic [31:0] e_inst, input logic e_st,
                       input logic e_bb, input logic e_ec);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; if_pc = pc; if_inst = inst; redirect = rd_i;
        ex_memread = mr; ex_rd = xr; ecall_done = done;
        e.name = name; e.valid = e_v; e.pc = e_pc; e.chk_pc = e_cpc;
        e.inst = e_inst; e.stall = e_st; e.bubble = e_bb; e.ecall = e_ec;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic ok;
            e = exp_q.pop_front();
            n_vec++;
            ok = (id_valid === e.valid) && (id_inst === e.inst) &&
                 (stall === e.stall) && (bubble === e.bubble) && (ecall === e.ecall) &&
                 (!e.chk_pc || id_pc === e.pc) &&
                 (id_opcode === e.inst[6:0]) && (id_rd === e.inst[11:7]) &&
                 (id_funct3 === e.inst[14:12]) && (id_rs1 === e.inst[19:15]) &&
                 (id_rs2 === e.inst[24:20]) && (id_funct7 === e.inst[31:25]);
            if (!ok) begin
                n_bad++;
                $display("FAIL %s: got v=%b pc=%h inst=%h rd=%0d rs1=%0d rs2=%0d st=%b bb=%b ec=%b, want v=%b pc=%h inst=%h st=%b bb=%b ec=%b",
                         e.name, id_valid, id_pc, id_inst, id_rd, id_rs1, id_rs2, stall, bubble, ecall,
                         e.valid, e.pc, e.inst, e.stall, e.bubble, e.ecall);
            end else begin
                $display("vec %s: v=%b pc=%h inst=%h st=%b bb=%b ec=%b",
                         e.name, id_valid, id_pc, id_inst, stall, bubble, ecall);
            end
        end
    end

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ADDI1 = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] ADD6  = 32'h0002_8333;  // add x6,x5,x0
    localparam logic [31:0] ADD8  = 32'h0070_0433;  // add x8,x0,x7
    localparam logic [31:0] ECALL = 32'h0000_0073;

    initial begin
        //  name            rst pc          inst           rdr mr rd done | v  pc         cpc inst          st bb ec
        cyc("reset",        0, 32'h0,      32'h0,         0, 0, 0, 0,     0, 32'h0,     1, NOP,          0, 0, 0);
        cyc("run_empty",    1, 32'h0,      ADDI1,         0, 0, 0, 0,     0, 32'h0,     1, NOP,          0, 0, 0);
        cyc("stream_pc0",   1, 32'h4,      ADDI1,         0, 0, 0, 0,     1, 32'h0,     1, ADDI1,        0, 0, 0);
        cyc("stream_pc4",   1, 32'h8,      ADD6,          0, 0, 0, 0,     1, 32'h4,     1, ADDI1,        0, 0, 0);
        cyc("hazard_rs1",   1, 32'hC,      ADDI1,         0, 1, 5, 0,     1, 32'h8,     1, ADD6,         1, 1, 0);
        cyc("stall_issue",  1, 32'hC,      ADDI1,         0, 0, 0, 0,     1, 32'h8,     1, ADD6,         0, 0, 0);
        cyc("after_stall",  1, 32'h10,     ADD6,          0, 1, 0, 0,     1, 32'hC,     1, ADDI1,        0, 0, 0);
        cyc("ex_rd_zero",   1, 32'h14,     ADDI1,         0, 1, 0, 0,     1, 32'h10,    1, ADD6,         0, 0, 0);
        cyc("pre_redir",    1, 32'h18,     ADD6,          0, 0, 0, 0,     1, 32'h14,    1, ADDI1,        0, 0, 0);
        cyc("haz_redirect", 1, 32'h1C,     ADDI1,         1, 1, 5, 0,     1, 32'h18,    1, ADD6,         0, 0, 0);
        cyc("flush_1",      1, 32'h100,    32'h00A00113,  0, 0, 0, 0,     0, 32'h0,     0, NOP,          0, 0, 0);
        cyc("flush_2",      1, 32'h104,    32'h00B00193,  0, 0, 0, 0,     0, 32'h0,     0, NOP,          0, 0, 0);
        cyc("target_valid", 1, 32'h108,    ECALL,         0, 0, 0, 0,     1, 32'h104,   1, 32'h00B00193, 0, 0, 0);
        cyc("ecall_slot",   1, 32'h10C,    32'h0,         1, 0, 0, 0,     1, 32'h108,   1, ECALL,        1, 0, 1);
        cyc("halt_2",       1, 32'h10C,    32'h0,         0, 1, 1, 0,     0, 32'h0,     0, NOP,          1, 0, 1);
        cyc("halt_3",       1, 32'h10C,    32'h0,         0, 0, 0, 0,     0, 32'h0,     0, NOP,          1, 0, 1);
        cyc("halt_4",       1, 32'h10C,    32'h0,         0, 0, 0, 0,     0, 32'h0,     0, NOP,          1, 0, 1);
        cyc("halt_done",    1, 32'h10C,    32'h0,         0, 0, 0, 1,     0, 32'h0,     0, NOP,          1, 0, 1);
        cyc("resume",       1, 32'h10C,    32'h00C00213,  0, 0, 0, 0,     0, 32'h0,     0, NOP,          0, 0, 0);
        cyc("resume_latch", 1, 32'h110,    32'h0,         0, 0, 0, 0,     1, 32'h10C,   1, 32'h00C00213, 0, 0, 0);
        cyc("fetch_nop",    1, 32'h114,    ECALL,         0, 0, 0, 0,     0, 32'h0,     0, NOP,          0, 0, 0);
        cyc("ecall2_slot",  1, 32'h118,    32'h0,         0, 0, 0, 0,     1, 32'h114,   1, ECALL,        1, 0, 1);
        cyc("halt2_hold",   1, 32'h118,    32'h0,         0, 0, 0, 0,     0, 32'h0,     0, NOP,          1, 0, 1);
        cyc("async_reset",  0, 32'h118,    32'h0,         0, 0, 0, 0,     0, 32'h0,     1, NOP,          0, 0, 0);
        cyc("post_reset",   1, 32'h200,    ADDI1,         0, 0, 0, 0,     0, 32'h0,     1, NOP,          0, 0, 0);
        cyc("post_latch",   1, 32'h204,    ADD8,          0, 0, 0, 0,     1, 32'h200,   1, ADDI1,        0, 0, 0);
        cyc("hazard_rs2",   1, 32'h208,    ADDI1,         0, 1, 7, 0,     1, 32'h204,   1, ADD8,         1, 1, 0);
        cyc("rs2_issue",    1, 32'h208,    ADDI1,         0, 0, 0, 0,     1, 32'h204,   1, ADD8,         0, 0, 0);
        cyc("rs2_next",     1, 32'h20C,    ADDI1,         0, 0, 0, 0,     1, 32'h208,   1, ADDI1,        0, 0, 0);
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL watchdog: simulation time %0t exceeded", $time);
        $fatal(1, "watchdog");
    end

endmodule
